// File: rtl/l2cache_tagv_array_if.sv
// Lookup, write and flush-control bundle for the L2 tag/valid array.
// The master drives lookups, writes and flush requests; the slave is the array itself.
interface l2cache_tagv_array_if #(
    parameter int SET_WIDTH = 4,
    parameter int TAG_WIDTH = 25,
    parameter int WAY       = 8
);
    localparam int WAY_W = $clog2(WAY);

    logic [SET_WIDTH-1:0] rd_addr;
    logic [TAG_WIDTH-1:0] cmp_tag;
    logic [WAY_W-1:0]     rd_way_sel;
    logic [TAG_WIDTH-1:0] rd_tag;
    logic [WAY-1:0]       valid;
    logic [WAY-1:0]       hit;
    logic                 hit_any;
    logic [WAY_W-1:0]     hit_idx;
    logic [SET_WIDTH-1:0] wr_addr;
    logic [TAG_WIDTH-1:0] wr_tag;
    logic [WAY-1:0]       wr_we;
    logic [WAY-1:0]       wr_inv;
    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;

    modport master (
        output rd_addr, cmp_tag, rd_way_sel, wr_addr, wr_tag, wr_we, wr_inv, flush_req,
        input  rd_tag, valid, hit, hit_any, hit_idx, flush_busy, flush_done
    );

    modport slave (
        input  rd_addr, cmp_tag, rd_way_sel, wr_addr, wr_tag, wr_we, wr_inv, flush_req,
        output rd_tag, valid, hit, hit_any, hit_idx, flush_busy, flush_done
    );
endinterface

// File: rtl/l2cache_tagv_array.sv
// L2 tag/valid store: registered lookup with write-first bypass, per-way write/invalidate,
// and a flush sequencer that clears every valid bit, one set per cycle.
module l2cache_tagv_array #(
    parameter int SET_WIDTH = 4,
    parameter int TAG_WIDTH = 25,
    parameter int WAY       = 8
) (
    input  logic                clk,
    input  logic                rstn,
    l2cache_tagv_array_if.slave bus
);
    localparam int WAY_W = $clog2(WAY);
    localparam int SETS  = 1 << SET_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [SET_WIDTH-1:0] cnt_r;
    logic [TAG_WIDTH-1:0] tag_mem_r [SETS][WAY];
    logic [WAY-1:0]       valid_mem_r [SETS];
    logic [WAY-1:0]       we_s;
    logic [WAY-1:0]       inv_s;
    logic [WAY-1:0]       byp_valid_s;
    logic [TAG_WIDTH-1:0] byp_tag_s [WAY];
    logic [WAY-1:0]       rd_valid_r;
    logic [TAG_WIDTH-1:0] rd_tag_r [WAY];
    logic [WAY_W-1:0]     rd_sel_r;
    logic [WAY-1:0]       hit_s;
    logic [WAY_W-1:0]     hit_idx_s;
    logic                 sweep_s;
    logic                 same_set_s;
    logic                 sweep_hit_s;

    // Writes are dropped while the sweep owns the valid array.
    assign sweep_s     = (state_r == ST_SWEEP);
    assign we_s        = sweep_s ? {WAY{1'b0}} : bus.wr_we;
    assign inv_s       = sweep_s ? {WAY{1'b0}} : bus.wr_inv;
    assign same_set_s  = (bus.wr_addr == bus.rd_addr);
    assign sweep_hit_s = sweep_s && (cnt_r == bus.rd_addr);

    // Flush FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Flush FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.flush_req) state_nx_s = ST_SWEEP;
                else               state_nx_s = ST_IDLE;
            end
            ST_SWEEP: begin
                if (cnt_r == {SET_WIDTH{1'b1}}) state_nx_s = ST_DONE;
                else                            state_nx_s = ST_SWEEP;
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Sweep set counter, parked at zero outside the sweep
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {SET_WIDTH{1'b0}};
        end else if (sweep_s) begin
            cnt_r <= cnt_r + SET_WIDTH'(1'b1);
        end else begin
            cnt_r <= {SET_WIDTH{1'b0}};
        end
    end

    // Valid storage: sweep clear, otherwise invalidate beats write per way
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SETS; s++) valid_mem_r[s] <= {WAY{1'b0}};
        end else if (sweep_s) begin
            valid_mem_r[cnt_r] <= {WAY{1'b0}};
        end else begin
            valid_mem_r[bus.wr_addr] <= (valid_mem_r[bus.wr_addr] | we_s) & ~inv_s;
        end
    end

    // Tag storage, never reset and never touched by the sweep
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAY; w++) begin
            if (we_s[w]) tag_mem_r[bus.wr_addr][w] <= bus.wr_tag;
        end
    end

    // Write-first bypass into the lookup register
    always_comb begin
        byp_valid_s = {WAY{1'b0}};
        for (int w = 0; w < WAY; w++) begin
            if (sweep_hit_s)                  byp_valid_s[w] = 1'b0;
            else if (same_set_s && inv_s[w])  byp_valid_s[w] = 1'b0;
            else if (same_set_s && we_s[w])   byp_valid_s[w] = 1'b1;
            else                              byp_valid_s[w] = valid_mem_r[bus.rd_addr][w];
            if (same_set_s && we_s[w]) byp_tag_s[w] = bus.wr_tag;
            else                       byp_tag_s[w] = tag_mem_r[bus.rd_addr][w];
        end
    end

    // Lookup register: one-cycle read of the addressed set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_r <= {WAY{1'b0}};
            rd_sel_r   <= {WAY_W{1'b0}};
            for (int w = 0; w < WAY; w++) rd_tag_r[w] <= {TAG_WIDTH{1'b0}};
        end else begin
            rd_valid_r <= byp_valid_s;
            rd_sel_r   <= bus.rd_way_sel;
            for (int w = 0; w < WAY; w++) rd_tag_r[w] <= byp_tag_s[w];
        end
    end

    // Tag compare against the live cmp_tag; lowest hitting way wins the index
    always_comb begin
        hit_s     = {WAY{1'b0}};
        hit_idx_s = {WAY_W{1'b0}};
        for (int w = 0; w < WAY; w++) begin
            hit_s[w] = rd_valid_r[w] && (rd_tag_r[w] == bus.cmp_tag);
        end
        for (int w = WAY - 1; w >= 0; w--) begin
            if (hit_s[w]) hit_idx_s = WAY_W'(w);
            else          hit_idx_s = hit_idx_s;
        end
    end

    assign bus.valid      = rd_valid_r;
    assign bus.rd_tag     = rd_tag_r[rd_sel_r];
    assign bus.hit        = hit_s;
    assign bus.hit_any    = |hit_s;
    assign bus.hit_idx    = hit_idx_s;
    assign bus.flush_busy = sweep_s;
    assign bus.flush_done = (state_r == ST_DONE);
endmodule

// File: tb/tb_l2cache_tagv_array.sv
// Randomized bench for l2cache_tagv_array against a write-then-read array model.
module tb_l2cache_tagv_array;
    localparam int SW = 4;
    localparam int TW = 25;
    localparam int NW = 8;
    localparam int NS = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    l2cache_tagv_array_if #(.SET_WIDTH(SW), .TAG_WIDTH(TW), .WAY(NW)) bus ();
    l2cache_tagv_array #(.SET_WIDTH(SW), .TAG_WIDTH(TW), .WAY(NW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference state: what each set/way should hold, plus the expected lookup row.
    bit            m_valid [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    bit            m_known [NS][NW];
    logic [NW-1:0] e_valid;
    logic [TW-1:0] e_tag   [NW];
    bit            e_known [NW];
    logic [2:0]    e_sel;

    // Apply a write then capture the read row (write-first), then clock the DUT.
    task automatic drive(input logic [SW-1:0] ra, input logic [2:0] sel, input logic [SW-1:0] wa,
                         input logic [TW-1:0] wt, input logic [NW-1:0] we, input logic [NW-1:0] inv);
        bus.rd_addr = ra; bus.rd_way_sel = sel; bus.wr_addr = wa;
        bus.wr_tag = wt; bus.wr_we = we; bus.wr_inv = inv;
        for (int w = 0; w < NW; w++) begin
            if (we[w]) begin m_tag[wa][w] = wt; m_known[wa][w] = 1'b1; m_valid[wa][w] = 1'b1; end
            if (inv[w]) m_valid[wa][w] = 1'b0;
        end
        for (int w = 0; w < NW; w++) begin
            e_valid[w] = m_valid[ra][w]; e_tag[w] = m_tag[ra][w]; e_known[w] = m_known[ra][w];
        end
        e_sel = sel;
        @(posedge clk); #1;
        bus.wr_we = 8'h00; bus.wr_inv = 8'h00;
    endtask

    function automatic logic [NW-1:0] exp_hit(input logic [TW-1:0] c);
        logic [NW-1:0] r;
        r = 8'h00;
        for (int w = 0; w < NW; w++) if (e_valid[w] && (e_tag[w] === c)) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] exp_idx(input logic [NW-1:0] h);
        for (int w = 0; w < NW; w++) if (h[w]) return 3'(w);
        return 3'd0;
    endfunction

    task automatic clear_model_valid();
        for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic test_reset();
        bus.rd_addr = 4'd0; bus.cmp_tag = 25'd0; bus.rd_way_sel = 3'd0; bus.wr_addr = 4'd0;
        bus.wr_tag = 25'd0; bus.wr_we = 8'h00; bus.wr_inv = 8'h00; bus.flush_req = 1'b0;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk_cnt++; if (bus.valid !== 8'h00) $display("FAIL reset.valid got %h exp 00", bus.valid); else pass_cnt++;
        chk_cnt++; if (bus.hit !== 8'h00) $display("FAIL reset.hit got %h exp 00", bus.hit); else pass_cnt++;
        chk_cnt++; if (bus.hit_any !== 1'b0) $display("FAIL reset.hit_any got %b exp 0", bus.hit_any); else pass_cnt++;
        chk_cnt++; if (bus.hit_idx !== 3'd0) $display("FAIL reset.hit_idx got %0d exp 0", bus.hit_idx); else pass_cnt++;
        chk_cnt++; if (bus.rd_tag !== 25'd0) $display("FAIL reset.rd_tag got %h exp 0", bus.rd_tag); else pass_cnt++;
        chk_cnt++; if (bus.flush_busy !== 1'b0) $display("FAIL reset.busy got %b exp 0", bus.flush_busy); else pass_cnt++;
        chk_cnt++; if (bus.flush_done !== 1'b0) $display("FAIL reset.done got %b exp 0", bus.flush_done); else pass_cnt++;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_hit_basic();
        drive(4'd0, 3'd0, 4'd3, 25'h0ABCDEF, 8'h20, 8'h00);
        drive(4'd3, 3'd5, 4'd0, 25'd0, 8'h00, 8'h00);
        bus.cmp_tag = 25'h0ABCDEF; #1;
        chk_cnt++; if (bus.hit !== 8'h20) $display("FAIL hit_basic.hit got %h exp 20", bus.hit); else pass_cnt++;
        chk_cnt++; if (bus.hit_idx !== 3'd5) $display("FAIL hit_basic.idx got %0d exp 5", bus.hit_idx); else pass_cnt++;
        chk_cnt++; if (bus.hit_any !== 1'b1) $display("FAIL hit_basic.any got %b exp 1", bus.hit_any); else pass_cnt++;
        chk_cnt++; if (bus.rd_tag !== 25'h0ABCDEF) $display("FAIL hit_basic.rd_tag got %h exp 0abcdef", bus.rd_tag); else pass_cnt++;
    endtask

    task automatic test_bypass();
        drive(4'd7, 3'd2, 4'd7, 25'h123, 8'h04, 8'h00);
        chk_cnt++; if (bus.valid[2] !== 1'b1) $display("FAIL bypass.valid2 got %b exp 1", bus.valid[2]); else pass_cnt++;
        chk_cnt++; if (bus.rd_tag !== 25'h123) $display("FAIL bypass.rd_tag got %h exp 123", bus.rd_tag); else pass_cnt++;
        chk_cnt++; if (bus.valid !== e_valid) $display("FAIL bypass.valid got %h exp %h", bus.valid, e_valid); else pass_cnt++;
    endtask

    task automatic test_we_inv();
        drive(4'd4, 3'd0, 4'd4, 25'h1555555, 8'h01, 8'h01);
        bus.cmp_tag = 25'h1555555; #1;
        chk_cnt++; if (bus.valid[0] !== 1'b0) $display("FAIL we_inv.valid0 got %b exp 0", bus.valid[0]); else pass_cnt++;
        chk_cnt++; if (bus.rd_tag !== 25'h1555555) $display("FAIL we_inv.rd_tag got %h exp 1555555", bus.rd_tag); else pass_cnt++;
        chk_cnt++; if (bus.hit !== 8'h00) $display("FAIL we_inv.hit got %h exp 00", bus.hit); else pass_cnt++;
        drive(4'd4, 3'd0, 4'd0, 25'd0, 8'h00, 8'h00);
        chk_cnt++; if (bus.valid[0] !== 1'b0) $display("FAIL we_inv.stored_valid0 got %b exp 0", bus.valid[0]); else pass_cnt++;
        chk_cnt++; if (bus.rd_tag !== 25'h1555555) $display("FAIL we_inv.stored_tag got %h exp 1555555", bus.rd_tag); else pass_cnt++;
    endtask

    task automatic test_multi_hit();
        drive(4'd0, 3'd0, 4'd9, 25'd0, 8'h00, 8'hFF);
        drive(4'd0, 3'd0, 4'd9, 25'h0777777, 8'h42, 8'h00);
        drive(4'd9, 3'd6, 4'd0, 25'd0, 8'h00, 8'h00);
        bus.cmp_tag = 25'h0777777; #1;
        chk_cnt++; if (bus.hit !== 8'h42) $display("FAIL multi_hit.hit got %h exp 42", bus.hit); else pass_cnt++;
        chk_cnt++; if (bus.hit_idx !== 3'd1) $display("FAIL multi_hit.idx got %0d exp 1", bus.hit_idx); else pass_cnt++;
        chk_cnt++; if (bus.rd_tag !== 25'h0777777) $display("FAIL multi_hit.rd_tag got %h exp 0777777", bus.rd_tag); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0]   r32;
        logic [SW-1:0] ra, wa;
        logic [NW-1:0] we, inv, eh;
        logic [TW-1:0] wt, c;
        logic [2:0]    sel, pick;
        for (int i = 0; i < 60; i++) begin
            ra  = 4'($urandom_range(0, 15));
            wa  = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
            sel = 3'($urandom_range(0, 7));
            r32 = $urandom & $urandom; we  = r32[7:0];
            r32 = $urandom & $urandom & $urandom; inv = r32[7:0];
            case ($urandom_range(0, 3))
                0:       wt = 25'h11;
                1:       wt = 25'h22;
                2:       wt = 25'h33;
                default: begin r32 = $urandom; wt = r32[24:0]; end
            endcase
            drive(ra, sel, wa, wt, we, inv);
            pick = 3'($urandom_range(0, 7));
            c = e_known[pick] ? e_tag[pick] : 25'h11;
            bus.cmp_tag = c; #1;
            eh = exp_hit(c);
            chk_cnt++; if (bus.valid !== e_valid) $display("FAIL rand.valid[%0d] got %h exp %h", i, bus.valid, e_valid); else pass_cnt++;
            chk_cnt++; if (bus.hit !== eh) $display("FAIL rand.hit[%0d] got %h exp %h", i, bus.hit, eh); else pass_cnt++;
            chk_cnt++; if (bus.hit_any !== (|eh)) $display("FAIL rand.any[%0d] got %b exp %b", i, bus.hit_any, |eh); else pass_cnt++;
            chk_cnt++; if (bus.hit_idx !== exp_idx(eh)) $display("FAIL rand.idx[%0d] got %0d exp %0d", i, bus.hit_idx, exp_idx(eh)); else pass_cnt++;
            if (e_known[e_sel]) begin
                chk_cnt++; if (bus.rd_tag !== e_tag[e_sel]) $display("FAIL rand.rd_tag[%0d] got %h exp %h", i, bus.rd_tag, e_tag[e_sel]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0]   r32;
        logic [SW-1:0] ra;
        logic [NW-1:0] ev;
        int busy_n, done_n, k;
        for (int s = 0; s < NS; s++) begin
            r32 = $urandom;
            drive(4'(s), 3'd0, 4'(s), r32[24:0], 8'hFF, 8'h00);
        end
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        busy_n = 0; done_n = 0; k = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.flush_done) begin done_n++; bus.flush_req = 1'b0; end
            if (bus.flush_busy) begin
                busy_n++;
                ra = ((k % 2) == 0 || k == 15) ? 4'(k) : 4'd15;
                bus.rd_addr = ra;
                if (k == 3) begin bus.wr_addr = 4'd0; bus.wr_we = 8'hFF; end
                @(posedge clk); #1;
                bus.wr_we = 8'h00;
                ev = (int'(ra) == k) ? 8'h00 : 8'hFF;
                chk_cnt++; if (bus.valid !== ev) $display("FAIL flush.sweep_valid[%0d] got %h exp %h", k, bus.valid, ev); else pass_cnt++;
                k++;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.flush_req = 1'b0;
        chk_cnt++; if (busy_n != 16) $display("FAIL flush.busy_cycles got %0d exp 16", busy_n); else pass_cnt++;
        chk_cnt++; if (done_n != 1) $display("FAIL flush.done_pulses got %0d exp 1", done_n); else pass_cnt++;
        clear_model_valid();
        for (int s = 0; s < NS; s++) begin
            drive(4'(s), 3'd0, 4'd0, 25'd0, 8'h00, 8'h00);
            chk_cnt++; if (bus.valid !== e_valid) $display("FAIL flush.after_valid[%0d] got %h exp %h", s, bus.valid, e_valid); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit done_seen;
        for (int s = 10; s < 13; s++) drive(4'(s), 3'd0, 4'(s), 25'h5A5A, 8'hFF, 8'h00);
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk_cnt++; if (bus.flush_busy !== 1'b1) $display("FAIL rst_sweep.busy_before got %b exp 1", bus.flush_busy); else pass_cnt++;
        rstn = 1'b0; #1;
        chk_cnt++; if (bus.flush_busy !== 1'b0) $display("FAIL rst_sweep.busy got %b exp 0", bus.flush_busy); else pass_cnt++;
        chk_cnt++; if (bus.flush_done !== 1'b0) $display("FAIL rst_sweep.done got %b exp 0", bus.flush_done); else pass_cnt++;
        @(negedge clk) rstn = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.flush_done || bus.flush_busy) done_seen = 1'b1;
        end
        chk_cnt++; if (done_seen !== 1'b0) $display("FAIL rst_sweep.late_activity got %b exp 0", done_seen); else pass_cnt++;
        clear_model_valid();
        for (int s = 0; s < NS; s++) begin
            drive(4'(s), 3'd0, 4'd0, 25'd0, 8'h00, 8'h00);
            chk_cnt++; if (bus.valid !== e_valid) $display("FAIL rst_sweep.valid[%0d] got %h exp %h", s, bus.valid, e_valid); else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hit_basic();
        test_bypass();
        test_we_inv();
        test_multi_hit();
        test_random();
        test_flush();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
